// File: rtl/register_scoreboard.sv
// register_scoreboard: tracks how many writers are in flight for each
// architectural register. Writers increment the count when they issue from ID
// and decrement it when they retire in WB. Decode asks whether its sources are
// busy, or whether its destination has no room left, and gets a stall
// decision back in the same cycle.
module register_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [ADDR_W-1:0]   issue_src1,
  input  logic [ADDR_W-1:0]   issue_src2,
  input  logic                issue_two_src,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic                hazard_detected,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_underflow,
  output logic [15:0]         stall_cycles
);

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;

  logic src1_busy;
  logic src2_busy;
  logic dest_full;
  logic inc;
  logic dec;
  logic underflow_now;

  // Source-busy lookup. If the bypass is enabled, a source whose last writer
  // is retiring in WB this cycle counts as free.
  always_comb begin
    src1_busy = (cnt[issue_src1] != '0);
    src2_busy = (cnt[issue_src2] != '0);
    if (WB_BYPASS != 0 && wb_valid) begin
      if (wb_dest == issue_src1 && cnt[issue_src1] == CNT_W'(1)) src1_busy = 1'b0;
      if (wb_dest == issue_src2 && cnt[issue_src2] == CNT_W'(1)) src2_busy = 1'b0;
    end
    dest_full = (cnt[issue_dest] == '1);
  end

  // Stall decision and issue handshake. Flush blocks the issue but does not
  // mask the hazard.
  always_comb begin
    hazard_detected = issue_valid &&
                      (src1_busy ||
                       (issue_two_src && src2_busy) ||
                       (issue_wb_en && dest_full));
    issue_accept    = issue_valid && !hazard_detected && !flush;
    inc             = issue_accept && issue_wb_en;
    dec             = wb_valid && (cnt[wb_dest] != '0);
    underflow_now   = wb_valid && (cnt[wb_dest] == '0);
  end

  // Next-state counters. If inc and dec hit the same register they cancel.
  // A writeback against a zero counter is not a decrement, so a same-cycle
  // issue to that register still takes the counter to 1.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_next[i] = cnt[i];
      if (inc && issue_dest == ADDR_W'(i) && !(dec && wb_dest == ADDR_W'(i)))
        cnt_next[i] = cnt[i] + CNT_W'(1);
      else if (dec && wb_dest == ADDR_W'(i) && !(inc && issue_dest == ADDR_W'(i)))
        cnt_next[i] = cnt[i] - CNT_W'(1);
      busy_next[i] = (cnt_next[i] != '0);
    end
  end

  // State: counters, registered busy mask, sticky underflow flag and the
  // saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      busy_mask    <= '0;
      wb_underflow <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_next[i];
      busy_mask <= busy_next;
      if (underflow_now) wb_underflow <= 1'b1;
      if (hazard_detected && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
